// File: rtl/logic_unit.sv
// Bitwise logic unit with an accumulator operand, a one-deep registered output
// stage using valid/ready handshakes on both sides, and an accepted-request counter.
module logic_unit #(
   parameter int WIDTH = 20,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic             acc_sel,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] y,
   output logic             zero,
   output logic             parity,
   output logic [CNT_W-1:0] op_count
);

   // Handshake: a transfer happens on a rising edge where valid && ready are
   // both high; valid never waits on ready, and held results stay stable until taken.
   typedef enum logic [2:0] {
      OP_AND   = 3'b000,
      OP_OR    = 3'b001,
      OP_XOR   = 3'b010,
      OP_NAND  = 3'b011,
      OP_NOR   = 3'b100,
      OP_XNOR  = 3'b101,
      OP_ANDN  = 3'b110,
      OP_PASSB = 3'b111
   } op_e;

   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] y_q, y_d;
   logic             zero_q, zero_d;
   logic             parity_q, parity_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CNT_W-1:0] op_count_q, op_count_d;

   logic             accept;
   logic [WIDTH-1:0] opnd_a;
   logic [WIDTH-1:0] result;

   // The output slot frees up in the same cycle it is drained, so the ready
   // path from out_ready is combinational and full throughput is sustained.
   assign in_ready = !rst && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign opnd_a   = acc_sel ? acc_q : a;

   always_comb begin
      result = '0;
      case (op_e'(op))
         OP_AND:   result = opnd_a & b;
         OP_OR:    result = opnd_a | b;
         OP_XOR:   result = opnd_a ^ b;
         OP_NAND:  result = ~(opnd_a & b);
         OP_NOR:   result = ~(opnd_a | b);
         OP_XNOR:  result = ~(opnd_a ^ b);
         OP_ANDN:  result = opnd_a & ~b;
         OP_PASSB: result = b;
         default:  result = '0;
      endcase
   end

   always_comb begin
      out_valid_d = out_valid_q;
      y_d         = y_q;
      zero_d      = zero_q;
      parity_d    = parity_q;
      acc_d       = acc_q;
      op_count_d  = op_count_q;
      if (accept) begin
         out_valid_d = 1'b1;
         y_d         = result;
         zero_d      = (result == '0);
         parity_d    = ^result;
         acc_d       = result;
         op_count_d  = op_count_q + CNT_W'(1);
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         zero_q      <= 1'b1;
         parity_q    <= 1'b0;
         acc_q       <= '0;
         op_count_q  <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         y_q         <= y_d;
         zero_q      <= zero_d;
         parity_q    <= parity_d;
         acc_q       <= acc_d;
         op_count_q  <= op_count_d;
      end
   end

   assign out_valid = out_valid_q;
   assign y         = y_q;
   assign zero      = zero_q;
   assign parity    = parity_q;
   assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit.sv
// Self-checking bench for logic_unit: directed scenarios plus randomized traffic
// against a behavioural model, with a queue-based scoreboard and output monitor.
module tb_logic_unit;

   localparam int W  = 20;
   localparam int CW = 4;
   localparam int EW = W + 2 + CW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [2:0]    op = '0;
   logic          acc_sel = 1'b0;
   logic [W-1:0]  a = '0;
   logic [W-1:0]  b = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  y;
   logic          zero;
   logic          parity;
   logic [CW-1:0] op_count;

   logic_unit #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .acc_sel(acc_sel), .a(a), .b(b),
      .out_valid(out_valid), .out_ready(out_ready),
      .y(y), .zero(zero), .parity(parity), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Scoreboard state and behavioural model of the unit
   logic [EW-1:0] exp_q[$];
   int            checks = 0;
   int            errors = 0;
   logic          checking = 1'b0;
   logic          m_ov = 1'b0;
   logic [W-1:0]  m_acc = '0;
   int            m_cnt = 0;
   logic          cur_ov = 1'b0;
   logic          exp_in_ready = 1'b0;
   logic          exp_reset_now = 1'b0;
   logic          prev_r = 1'b0;
   logic          flush_pending = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] ref_result(input logic [2:0] o, input logic [W-1:0] xa,
                                               input logic [W-1:0] xb);
      logic [W-1:0] r;
      case (o)
         3'd0: r = xa & xb;
         3'd1: r = xa | xb;
         3'd2: r = xa ^ xb;
         3'd3: r = ~(xa & xb);
         3'd4: r = ~(xa | xb);
         3'd5: r = ~(xa ^ xb);
         3'd6: r = xa & ~xb;
         default: r = xb;
      endcase
      return r;
   endfunction

   // One cycle of stimulus: drive just after the rising edge, predict the next edge.
   task automatic step(input logic v, input logic [2:0] o, input logic s,
                       input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic ordy, input logic r);
      logic [W-1:0] res;
      @(posedge clk);
      #1;
      if (flush_pending) begin
         exp_q.delete();
         flush_pending = 1'b0;
      end
      in_valid  = v;
      op        = o;
      acc_sel   = s;
      a         = aa;
      b         = bb;
      out_ready = ordy;
      rst       = r;
      exp_reset_now = prev_r;
      prev_r        = r;
      cur_ov        = m_ov;
      exp_in_ready  = !r && (!m_ov || ordy);
      if (r) begin
         m_ov  = 1'b0;
         m_acc = '0;
         m_cnt = 0;
         flush_pending = 1'b1;
      end else if (v && exp_in_ready) begin
         res   = ref_result(o, s ? m_acc : aa, bb);
         m_acc = res;
         m_cnt = (m_cnt + 1) % (1 << CW);
         m_ov  = 1'b1;
         exp_q.push_back({res, (res == '0), ^res, CW'(m_cnt)});
      end else if (m_ov && ordy) begin
         m_ov = 1'b0;
      end
   endtask

   // Monitor: compares whatever the unit presents against the scoreboard head
   always @(negedge clk) begin
      logic [EW-1:0] e;
      if (checking) begin
         chk("in_ready", in_ready, exp_in_ready);
         chk("out_valid", out_valid, cur_ov);
         if (exp_reset_now) begin
            chk("rst_y", y, 0);
            chk("rst_zero", zero, 1);
            chk("rst_parity", parity, 0);
            chk("rst_op_count", op_count, 0);
         end
         if (out_valid) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_result", 1, 0);
            end else begin
               e = exp_q[0];
               chk("y", y, e[EW-1 -: W]);
               chk("zero", zero, e[CW+1]);
               chk("parity", parity, e[CW]);
               chk("op_count", op_count, e[CW-1:0]);
               if (out_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      logic [W-1:0] ra, rb;
      step(0, 3'd0, 0, '0, '0, 0, 1);
      step(1, 3'd0, 0, '0, '0, 1, 1);
      checking = 1'b1;
      // AND of complementary patterns
      step(1, 3'd0, 0, 20'hAAAAA, 20'h55555, 1, 0);
      // XOR, OR, NAND back-to-back on all-ones
      step(1, 3'd2, 0, 20'hFFFFF, 20'hFFFFF, 1, 0);
      step(1, 3'd1, 0, 20'hFFFFF, 20'hFFFFF, 1, 0);
      step(1, 3'd3, 0, 20'hFFFFF, 20'hFFFFF, 1, 0);
      // accumulator chaining with no bubble
      step(1, 3'd7, 0, 20'h12345, 20'h0F0F0, 1, 0);
      step(1, 3'd0, 1, 20'h00000, 20'h00FF0, 1, 0);
      step(1, 3'd2, 1, 20'h00000, 20'hFFFFF, 1, 0);
      // consumer stall with a request waiting, then resume
      step(1, 3'd6, 0, 20'hABCDE, 20'h0000F, 0, 0);
      step(1, 3'd6, 0, 20'hABCDE, 20'h0000F, 0, 0);
      step(1, 3'd6, 0, 20'hABCDE, 20'h0000F, 0, 0);
      step(1, 3'd6, 0, 20'hABCDE, 20'h0000F, 1, 0);
      step(1, 3'd4, 0, 20'h00F00, 20'h0000F, 1, 0);
      step(1, 3'd5, 0, 20'h00F00, 20'h0000F, 1, 0);
      // reset with a pending result and a loaded accumulator
      step(1, 3'd7, 0, 20'h00000, 20'hFFF0F, 1, 0);
      step(1, 3'd1, 1, 20'h00000, 20'h00001, 0, 1);
      step(1, 3'd1, 1, 20'h00000, 20'h00001, 1, 0);
      // counter wrap: 17 consecutive accepts
      for (int i = 0; i < 17; i++) step(1, 3'd7, 0, '0, W'(i), 1, 0);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         step($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
              ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0);
      end
      for (int i = 0; i < 4; i++) step(0, 3'd0, 0, '0, '0, 1, 0);
      @(negedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/logic_unit.md
LOGIC_UNIT -- requirements
Module: logic_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 20: operand/result width in bits, legal range 1..64.
REQ-002 SHALL have parameter CNT_W, default 16: width of the transaction counter.
REQ-003 SHALL have port clk  input  1  rising-edge clock; the only clock.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request this cycle.
REQ-007 SHALL have port op  input  3  operation select (REQ-014).
REQ-008 SHALL have port acc_sel  input  1  1 = use accumulator in place of a.
REQ-009 SHALL have port a  input  WIDTH  operand A.
REQ-010 SHALL have port b  input  WIDTH  operand B.
REQ-011 SHALL have port out_valid  output  1  y/zero/parity hold a result.
REQ-012 SHALL have port out_ready  input  1  consumer accepts the result this cycle.
REQ-013 SHALL have ports y  output  WIDTH  registered result; zero  output  1  y==0; parity  output  1  XOR-reduce of y; op_count  output  CNT_W  accepted-request count.

Function
REQ-014 Op encoding SHALL be: 000 AND, 001 OR, 010 XOR, 011 NAND, 100 NOR, 101 XNOR, 110 ANDN (A & ~B), 111 PASS_B (result = B).
REQ-015 Operand A SHALL be the accumulator register when acc_sel=1, else port a; B SHALL always be port b.
REQ-016 Accept SHALL occur on a rising edge where in_valid && in_ready.
REQ-017 in_ready SHALL equal !rst && (!out_valid || out_ready); combinational path from out_ready is permitted.
REQ-018 On accept, y, zero, parity SHALL load the result of the presented request at that edge; out_valid SHALL be 1 the following cycle (latency 1 cycle).
REQ-019 Output drained (out_valid && out_ready) with no accept in the same cycle SHALL clear out_valid; y, zero, parity SHALL hold their last values.
REQ-020 Simultaneous drain and accept SHALL keep out_valid=1 and load the new result, giving one result per cycle sustained throughput.
REQ-021 While out_valid=1 and out_ready=0, y, zero, parity, out_valid SHALL remain stable and no request SHALL be accepted.
REQ-022 Accumulator SHALL load the result on every accept (whether acc_sel is 0 or 1), so it always equals the last accepted result.
REQ-023 Back-to-back accepts with acc_sel=1 SHALL use the result of the immediately preceding accept, with no bubble.
REQ-024 op_count SHALL increment by 1 on each accept and wrap from 2^CNT_W-1 to 0.
REQ-025 Inputs op, acc_sel, a, b SHALL be don't-care when in_valid=0.
REQ-026 The result SHALL be exactly WIDTH bits with no carry or overflow; zero and parity SHALL be computed from the WIDTH-bit result.

Reset
REQ-027 When rst=1 at a rising edge, the next state SHALL be out_valid=0, y=0, zero=1, parity=0, accumulator=0, op_count=0, regardless of in_valid/out_ready.
REQ-028 in_ready SHALL be 0 during any cycle with rst=1; a request presented then SHALL be discarded and not counted.
REQ-029 A result pending at reset (out_valid=1) SHALL be dropped.

Verification
REQ-030 a=AAAAA, b=55555, op=AND, acc_sel=0 -> next cycle y=00000, zero=1, parity=0, out_valid=1, op_count=1.
REQ-031 a=b=FFFFF with op=XOR, then OR, then NAND, back-to-back, out_ready=1 -> y=00000, then FFFFF with parity=0, then 00000 on consecutive cycles.
REQ-032 PASS_B b=0F0F0; then acc_sel=1 AND b=00FF0; then acc_sel=1 XOR b=FFFFF, consecutive cycles -> y=0F0F0, 000F0, FFF0F.
REQ-033 out_ready=0 for 3 cycles with out_valid=1 and in_valid=1 -> y stable, in_ready=0, op_count unchanged; out_ready=1 -> one accept per cycle resumes.
REQ-034 rst asserted for 1 cycle while out_valid=1 and accumulator=FFF0F -> next cycle out_valid=0, y=0, zero=1, op_count=0; acc_sel=1 OR b=00001 -> y=00001.
REQ-035 CNT_W=4, 16 accepts -> op_count returns to 0; 17th accept -> op_count=1.
